gray_updown_counter: RTL and testbench
======================================

Name: gray_updown_counter

Overview:
- Parametrised N-bit Gray-code counter with up/down counting, synchronous clear, parallel load and a wrap/saturate mode.
- Gray output and binary shadow are both registered and glitch-free; a one-cycle wrap pulse is provided for cascading.
- Next generation of the team's fixed up-only Gray counter.
- Used for FIFO pointers, position encoders and clock-domain-crossing counters.

Parameters:
- N, 4, counter width in bits (legal range 2..32).
- RST_VAL, 0, binary value loaded on reset (0..2**N-1); gray_out resets to its Gray encoding.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  count enable; one step per cycle while high
- up_dn  in  1  1 = count up, 0 = count down
- mode  in  1  0 = wrap at terminal value, 1 = saturate at terminal value
- clr  in  1  synchronous clear to binary 0
- load  in  1  synchronous parallel load
- load_val  in  N  binary value to load
- gray_out  out  N  registered Gray-coded count
- bin_out  out  N  registered binary count
- wrap  out  1  registered one-cycle pulse after a wrap transition
- sat  out  1  registered; high while saturated and en requests a step past the terminal value

Behaviour:
- Reset (rst=0, asynchronous):
  - bin_out = RST_VAL; gray_out = RST_VAL ^ (RST_VAL>>1).
  - wrap = 0; sat = 0.
- Release: first count edge is the first rising clk with rst=1.
- State: the internal state is the binary count B. Outputs are registered:
  - bin_out = B.
  - gray_out = next_B ^ (next_B>>1), registered in the same edge as B.
  - No combinational path from any input to any output.
- Priority at each edge: clr > load > en.
  - clr=1: B <= 0; wrap <= 0; sat <= 0.
  - load=1: B <= load_val; wrap <= 0; sat <= 0. The Gray output may change multiple bits on clr or load; this is permitted.
  - en=1, up_dn=1, B != 2**N-1: B <= B+1.
  - en=1, up_dn=0, B != 0: B <= B-1.
  - Terminal value is 2**N-1 when counting up and 0 when counting down.
- Step at the terminal value (en=1):
  - mode=0: B wraps (up: to 0; down: to 2**N-1); wrap <= 1 for exactly one cycle; sat <= 0.
  - mode=1: B holds; sat <= 1; wrap <= 0.
- en=0: B holds; wrap <= 0; sat <= 0.
- Latency: an input sampled at edge k is visible on the outputs after edge k; one cycle.
- Direction change: up_dn may change every cycle. Each step uses the up_dn value sampled at that edge.
- Single-bit property: every en-driven step, including wrap, changes exactly one gray_out bit. Saturated holds change zero bits.
- Arithmetic: modulo 2**N. No width growth.
- Mid-operation reset: outputs return to reset values immediately, independent of clk.

Optional Feature:
- Macro: GRAY_STEP_CHECK_EN.
- With the macro defined:
  - Adds output port step_err (1 bit, registered, sticky).
  - step_err sets when gray_out changes more than one bit across an edge where neither clr nor load was active.
  - step_err clears only on reset or clr.
- Without the macro: the port and its logic are absent; the interface is otherwise identical.

Decomposition:
- Package gray_pkg contains:
  - function bin2gray(N-bit).
  - function gray2bin(N-bit), using an XOR prefix from the MSB.
  - constants MODE_WRAP = 1'b0, MODE_SAT = 1'b1.
  - function popcount_gt1, used by the step check.
- One sub-module: gray_next_calc.
  - Combinational.
  - Takes B, en, up_dn, mode, clr, load and load_val.
  - Returns next_B, wrap_nxt and sat_nxt.
- The top level holds the registers, the gray encode and the optional checker.

Test Plan:
1. Reset, then N=4, RST_VAL=0, en=1, up_dn=1, mode=0 for 16 cycles -> gray_out = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0; wrap=1 for one cycle after the 8->0 step; every step changes one bit.
2. load=1, load_val=2, then en=1, up_dn=0, mode=0 for 4 cycles -> bin_out = 2,1,0,F,E; wrap pulses once after 0->F.
3. load_val=E, then up_dn=1, mode=1 for 4 cycles -> bin_out = E,F,F,F; sat=1 from the cycle after the step onto F is attempted; wrap stays 0.
4. clr=1, load=1, en=1 in the same cycle at B=9 -> bin_out=0, gray_out=0, wrap=0, sat=0.
5. Drop rst low mid-count at B=7, between clock edges -> outputs reset to RST_VAL immediately; counting resumes from RST_VAL after release.
6. With GRAY_STEP_CHECK_EN defined, force a two-bit register corruption through the bench -> step_err=1 and sticky until clr; a normal 1000-cycle random en/up_dn/mode run keeps step_err=0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and mode constants for the up/down Gray counter.
// Functions operate on 32-bit vectors; callers zero-extend and truncate to N bits.
package gray_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit of x is set: clearing the lowest set bit leaves a nonzero value.
  function automatic logic popcount_gt1(input logic [31:0] x);
    return (x & (x - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/gray_next_calc.sv
// Combinational next-state logic for the Gray counter's binary count.
// Applies clr > load > en priority, plus wrap/saturate handling at the terminal values.
module gray_next_calc
  import gray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] b,
  input  logic         en,
  input  logic         up_dn,
  input  logic         mode,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] next_b,
  output logic         wrap_nxt,
  output logic         sat_nxt
);

  localparam logic [N-1:0] B_MAX = {N{1'b1}};
  localparam logic [N-1:0] B_MIN = '0;

  // NOTE: every output gets a default before the if/else tree, so no path can infer a latch.
  always_comb begin
    next_b   = b;
    wrap_nxt = 1'b0;
    sat_nxt  = 1'b0;
    if (clr) begin
      next_b = '0;
    end else if (load) begin
      next_b = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (b != B_MAX) begin
          next_b = b + 1'b1;
        end else if (mode == MODE_SAT) begin
          sat_nxt = 1'b1;
        end else begin
          next_b   = B_MIN;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (b != B_MIN) begin
          next_b = b - 1'b1;
        end else if (mode == MODE_SAT) begin
          sat_nxt = 1'b1;
        end else begin
          next_b   = B_MAX;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gray_updown_counter.sv
// N-bit up/down Gray counter with registered Gray and binary outputs, wrap pulse and saturate flag.
// Define GRAY_STEP_CHECK_EN to add the sticky step_err output flagging multi-bit Gray steps.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int          N       = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         mode,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] gray_out,
  output logic [N-1:0] bin_out,
  output logic         wrap,
  output logic         sat
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic         step_err
`endif
);

  localparam logic [N-1:0] RST_B = RST_VAL[N-1:0];
  localparam logic [31:0]  RST_G32 = bin2gray(32'(RST_B));
  localparam logic [N-1:0] RST_G = RST_G32[N-1:0];

  logic [N-1:0] bin_q;
  logic [N-1:0] next_b;
  logic [N-1:0] gray_nxt;
  logic [31:0]  gray_nxt32;
  logic         wrap_nxt;
  logic         sat_nxt;

  gray_next_calc #(.N(N)) u_next (
    .b        (bin_q),
    .en       (en),
    .up_dn    (up_dn),
    .mode     (mode),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .next_b   (next_b),
    .wrap_nxt (wrap_nxt),
    .sat_nxt  (sat_nxt)
  );

  // Gray is encoded from next_b so both outputs update on the same edge, glitch-free.
  assign gray_nxt32 = bin2gray(32'(next_b));
  assign gray_nxt   = gray_nxt32[N-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q    <= RST_B;
      gray_out <= RST_G;
      wrap     <= 1'b0;
      sat      <= 1'b0;
    end else begin
      bin_q    <= next_b;
      gray_out <= gray_nxt;
      wrap     <= wrap_nxt;
      sat      <= sat_nxt;
    end
  end

  assign bin_out = bin_q;

`ifdef GRAY_STEP_CHECK_EN
  // Clr and load legitimately jump several bits, so only count/hold edges are checked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_err <= 1'b0;
    end else if (clr) begin
      step_err <= 1'b0;
    end else if (!load && popcount_gt1(32'(gray_out ^ gray_nxt))) begin
      step_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed self-checking bench for gray_updown_counter (N=4, RST_VAL=0).
// Step-error checks are compiled in only when GRAY_STEP_CHECK_EN is defined.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, mode, clr, load;
  logic [3:0] load_val;
  logic [3:0] gray_out, bin_out;
  logic       wrap, sat;
`ifdef GRAY_STEP_CHECK_EN
  logic       step_err;
`endif

  int passed = 0;
  int total  = 0;

  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_updown_counter #(.N(4), .RST_VAL(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .mode     (mode),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .gray_out (gray_out),
    .bin_out  (bin_out),
    .wrap     (wrap),
    .sat      (sat)
`ifdef GRAY_STEP_CHECK_EN
    ,
    .step_err (step_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string name, input logic [3:0] eb, input logic ew, input logic es);
    total++;
    if (bin_out !== eb) $display("FAIL %s bin_out: got %h expected %h", name, bin_out, eb);
    else passed++;
    total++;
    if (gray_out !== gray_tab[eb]) $display("FAIL %s gray_out: got %h expected %h", name, gray_out, gray_tab[eb]);
    else passed++;
    total++;
    if (wrap !== ew) $display("FAIL %s wrap: got %b expected %b", name, wrap, ew);
    else passed++;
    total++;
    if (sat !== es) $display("FAIL %s sat: got %b expected %b", name, sat, es);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 0; up_dn = 1; mode = 0; clr = 0; load = 0; load_val = 4'h0;
    #12;
    chk_outs("reset_hold", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_outs("reset_release", 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_up_wrap();
    logic [3:0] prev;
    en = 1; up_dn = 1; mode = 0;
    for (int i = 0; i < 16; i++) begin
      prev = gray_out;
      step();
      chk_outs($sformatf("up_wrap[%0d]", i), 4'((i + 1) % 16), (i == 15), 1'b0);
      total++;
      if ($countones(prev ^ gray_out) != 1)
        $display("FAIL up_wrap_onebit[%0d]: changed %0d bits expected 1", i, $countones(prev ^ gray_out));
      else passed++;
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_b [4] = '{4'h1, 4'h0, 4'hF, 4'hE};
    en = 0; load = 1; load_val = 4'h2;
    step();
    load = 0;
    chk_outs("down_load", 4'h2, 1'b0, 1'b0);
    en = 1; up_dn = 0; mode = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_outs($sformatf("down_wrap[%0d]", i), exp_b[i], (i == 2), 1'b0);
    end
  endtask

  task automatic test_saturate();
    en = 0; load = 1; load_val = 4'hE;
    step();
    load = 0;
    chk_outs("sat_load", 4'hE, 1'b0, 1'b0);
    en = 1; up_dn = 1; mode = 1;
    step(); chk_outs("sat_up0", 4'hF, 1'b0, 1'b0);
    step(); chk_outs("sat_up1", 4'hF, 1'b0, 1'b1);
    step(); chk_outs("sat_up2", 4'hF, 1'b0, 1'b1);
    en = 0;
    step(); chk_outs("sat_idle", 4'hF, 1'b0, 1'b0);
    load = 1; load_val = 4'h1;
    step();
    load = 0; en = 1; up_dn = 0;
    step(); chk_outs("sat_dn0", 4'h0, 1'b0, 1'b0);
    step(); chk_outs("sat_dn1", 4'h0, 1'b0, 1'b1);
    mode = 0;
    step(); chk_outs("sat_to_wrap", 4'hF, 1'b1, 1'b0);
  endtask

  task automatic test_direction();
    en = 0; load = 1; load_val = 4'h5;
    step();
    load = 0; en = 1; mode = 0;
    up_dn = 1; step(); chk_outs("dir_up", 4'h6, 1'b0, 1'b0);
    up_dn = 0; step(); chk_outs("dir_dn", 4'h5, 1'b0, 1'b0);
    up_dn = 1; step(); chk_outs("dir_up2", 4'h6, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    en = 0; load = 1; load_val = 4'h9;
    step();
    load = 0;
    chk_outs("prio_pre", 4'h9, 1'b0, 1'b0);
    clr = 1; load = 1; load_val = 4'h5; en = 1; up_dn = 1;
    step();
    clr = 0; load = 0; en = 0;
    chk_outs("prio_clr", 4'h0, 1'b0, 1'b0);
    load = 1; load_val = 4'hF; en = 1; up_dn = 1; mode = 0;
    step();
    load = 0; en = 0;
    chk_outs("prio_load", 4'hF, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    clr = 1;
    step();
    clr = 0; en = 1; up_dn = 1; mode = 0;
    for (int i = 0; i < 7; i++) step();
    chk_outs("mid_pre", 4'h7, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_outs("mid_async", 4'h0, 1'b0, 1'b0);
    step();
    chk_outs("mid_held", 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_outs("mid_resume", 4'h1, 1'b0, 1'b0);
  endtask

`ifdef GRAY_STEP_CHECK_EN
  task automatic test_step_check();
    int bad_clean = 0;
    clr = 1; load = 0; en = 0;
    step();
    clr = 0;
    for (int i = 0; i < 1000; i++) begin
      en = 1'($urandom_range(0, 1));
      up_dn = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      step();
      if (step_err !== 1'b0) bad_clean++;
    end
    total++;
    if (bad_clean != 0) $display("FAIL step_err_clean: got %0d cycles high expected 0", bad_clean);
    else passed++;
    clr = 1; en = 0;
    step();
    clr = 0;
    force dut.bin_q = 4'h5;
    step();
    release dut.bin_q;
    step();
    total++;
    if (step_err !== 1'b1) $display("FAIL step_err_set: got %b expected 1", step_err);
    else passed++;
    en = 1; up_dn = 1; mode = 0;
    step(); step();
    total++;
    if (step_err !== 1'b1) $display("FAIL step_err_sticky: got %b expected 1", step_err);
    else passed++;
    clr = 1;
    step();
    clr = 0; en = 0;
    total++;
    if (step_err !== 1'b0) $display("FAIL step_err_clr: got %b expected 0", step_err);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_direction();
    test_priority();
    test_async_reset();
`ifdef GRAY_STEP_CHECK_EN
    test_step_check();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
